// File: rtl/bit_serial_pkg.sv
// Shared types and limits for the bit-serial adder.
package bit_serial_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 64;
endpackage

// File: rtl/half_adder.sv
// Combinational half adder: {y, x} in, {carry, sum} out.
module half_adder (
  input  logic [1:0] xy,
  output logic [1:0] cs
);
  assign cs = {xy[1] & xy[0], xy[1] ^ xy[0]};
endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder with a registered carry and valid/ready on both sides.
module bit_serial_adder
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
);
  localparam int CW = $clog2(WIDTH);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("bit_serial_adder: WIDTH out of range");
  end

  state_t           state;
  logic [WIDTH-1:0] sa, sb;
  logic [WIDTH-2:0] res;
  logic             c;
  logic [CW-1:0]    cnt;
  logic [1:0]       ha1, ha2;
  logic             c_nxt;
  logic [WIDTH-1:0] res_full;
  logic             accept;

  half_adder u_ha1 (.xy({sb[0], sa[0]}), .cs(ha1));
  half_adder u_ha2 (.xy({c, ha1[0]}),    .cs(ha2));

  assign c_nxt    = ha1[1] | ha2[1];
  // Only WIDTH-1 bits need storing; the final bit joins them on the last edge.
  assign res_full = {ha2[0], res};
  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      sum       <= '0;
      sa        <= '0;
      sb        <= '0;
      res       <= '0;
      c         <= 1'b0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) state <= RUN;
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= res_full[WIDTH-1:1];
          c   <= c_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            sum       <= {c_nxt, res_full};
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= in_valid ? RUN : IDLE;
        end
        default: state <= IDLE;
      endcase
      if (accept) begin
        sa  <= a;
        sb  <= b;
        res <= '0;
        c   <= 1'b0;
        cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_bit_serial_adder.sv
// Randomised and directed bench for bit_serial_adder against a plain a+b model.
module tb_bit_serial_adder;
  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W:0]   sum;

  int n_chk = 0;
  int n_pass = 0;
  int n_out = 0;
  logic [W:0] exp_q[$];

  bit_serial_adder #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .sum(sum)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: every accepted pair must come back exactly once, in order.
  always @(negedge clock) begin
    if (!reset_n) exp_q.delete();
    else begin
      if (in_valid && in_ready) exp_q.push_back({1'b0, a} + {1'b0, b});
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) chk("sb_extra", 64'd1, 64'd0);
        else chk("sb_sum", 64'(sum), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input int stall, input string tag);
    int lat;
    logic [W:0] exp, held;
    exp = {1'b0, x} + {1'b0, y};
    lat = 0;
    while (!in_ready && lat < 40) begin tick(); lat++; end
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; a = x; b = y; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick(); lat++;
      a = W'($urandom); b = W'($urandom);
    end
    chk({tag, "_lat"}, 64'(lat), 64'd8);
    chk({tag, "_sum"}, 64'(sum), 64'(exp));
    held = sum;
    repeat (stall) begin
      a = W'($urandom); b = W'($urandom); in_valid = 1'($urandom_range(0, 1));
      tick();
      chk({tag, "_hold_v"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_s"}, 64'(sum), 64'(held));
      chk({tag, "_hold_r"}, 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle_v"}, 64'(out_valid), 64'd0);
    chk({tag, "_idle_r"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    reset_n = 1'b1;
    tick();

    op(8'h00, 8'h00, 0, "zero");
    op(8'hFF, 8'h01, 0, "ripple");
    op(8'hFF, 8'hFF, 0, "max");
    op(8'hA5, 8'h5A, 5, "stall");

    // Back-to-back: DONE hands straight to RUN with both handshakes high.
    in_valid = 1'b1; out_ready = 1'b1; a = 8'h12; b = 8'h34;
    tick();
    a = 8'h80; b = 8'h80;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      tick();
      chk("b2b_ready", 64'(in_ready), 64'(cyc == 8 || cyc == 17));
      chk("b2b_valid", 64'(out_valid), 64'(cyc == 8 || cyc == 17));
      if (cyc == 8) chk("b2b_sum1", 64'(sum), 64'h046);
      if (cyc == 17) begin
        chk("b2b_sum2", 64'(sum), 64'h100);
        in_valid = 1'b0;
      end
    end
    tick();
    out_ready = 1'b0;
    chk("b2b_idle_r", 64'(in_ready), 64'd1);
    chk("b2b_idle_v", 64'(out_valid), 64'd0);

    // Abort mid-RUN at cnt=4.
    in_valid = 1'b1; a = 8'h11; b = 8'h22;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_ready", 64'(in_ready), 64'd1);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    tick();
    op(8'h03, 8'h04, 0, "post_rst");

    for (int i = 0; i < 1000; i++) begin
      op(W'($urandom), W'($urandom), $urandom_range(0, 3), "rnd");
      repeat ($urandom_range(0, 2)) tick();
    end

    tick();
    chk("sb_left", 64'(exp_q.size()), 64'd0);
    chk("n_out", 64'(n_out), 64'd1007);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
